mmu_fork_sync: RTL and testbench

- Clocked, parametrised N-way fork for the MMU handshake fabric.
- One upstream token (payload plus branch mask) is broadcast to every selected downstream branch.
- Branches are eager: each branch completes its own handshake independently, and upstream is freed only when all selected branches have accepted.
- Synchronous successor of the 3-port click splitter. Adds payload width, per-token branch masking, a zero-bubble back-to-back mode and an optional stall counter.

---
 rtl/mmu_hs_pkg.sv | 18 +
 rtl/fork_branch_slot.sv | 26 ++
 rtl/mmu_fork_sync.sv | 94 +++++++++
 tb/tb_mmu_fork_sync.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_hs_pkg.sv
// Shared definitions for the MMU handshake fabric (fork now, join later).
package mmu_hs_pkg;

    localparam int MAX_PORTS   = 16;
    localparam int STALL_CNT_W = 16;

    typedef enum logic {
        FORK_IDLE = 1'b0,
        FORK_BUSY = 1'b1
    } fork_state_e;

    // True when every still-pending branch is ready this cycle, or nothing is pending.
    function automatic logic all_done(input logic [MAX_PORTS-1:0] pend,
                                      input logic [MAX_PORTS-1:0] free);
        return &(~pend | free);
    endfunction

endpackage

// File: rtl/fork_branch_slot.sv
// One branch of the fork: a single pending bit with clear > load > fire priority.
module fork_branch_slot (
    input  logic clk,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_load_val,
    input  logic i_fire,
    output logic o_pend
);

    logic r_pend;

    // Load beats fire so a new token can land in the cycle the old one completes.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_pend <= 1'b0;
        end else if (i_load) begin
            r_pend <= i_load_val;
        end else if (i_fire) begin
            r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/mmu_fork_sync.sv
// Eager N-way fork: broadcasts one upstream token to every masked branch.
// Define MMU_FORK_STALL_CNT_EN to add the saturating o_stallCnt port.
module mmu_fork_sync
    import mmu_hs_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 32,
    parameter int FULL_THRU = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_drive,
    output logic                 o_free,
    input  logic [DATA_W-1:0]    i_data,
    input  logic [NUM_PORTS-1:0] i_mask,
    output logic [NUM_PORTS-1:0] o_driveNext,
    input  logic [NUM_PORTS-1:0] i_freeNext,
    output logic [DATA_W-1:0]    o_data,
`ifdef MMU_FORK_STALL_CNT_EN
    output logic                 o_busy,
    output logic [STALL_CNT_W-1:0] o_stallCnt
`else
    output logic                 o_busy
`endif
);

    logic [NUM_PORTS-1:0] w_pend;
    logic [NUM_PORTS-1:0] w_fire;
    logic [MAX_PORTS-1:0] w_pend_ext;
    logic [MAX_PORTS-1:0] w_free_ext;
    logic                 w_last;
    logic                 w_accept;
    fork_state_e          w_state;
    logic [DATA_W-1:0]    r_data;

    always_comb begin
        w_pend_ext                  = '0;
        w_free_ext                  = '0;
        w_pend_ext[NUM_PORTS-1:0]   = w_pend;
        w_free_ext[NUM_PORTS-1:0]   = i_freeNext;
    end

    assign w_state  = (w_pend != '0) ? FORK_BUSY : FORK_IDLE;
    assign w_last   = all_done(w_pend_ext, w_free_ext);
    assign w_fire   = w_pend & i_freeNext;
    assign o_free   = (FULL_THRU != 0) ? w_last : (w_state == FORK_IDLE);
    assign w_accept = i_drive & o_free;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        fork_branch_slot u_slot (
            .clk        (clk),
            .i_clear    (rst),
            .i_load     (w_accept),
            .i_load_val (i_mask[g]),
            .i_fire     (w_fire[g]),
            .o_pend     (w_pend[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= i_data;
        end
    end

    assign o_driveNext = w_pend;
    assign o_data      = r_data;
    assign o_busy      = (w_state == FORK_BUSY);

`ifdef MMU_FORK_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Counts cycles where some held branch is waiting; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (((w_pend & ~i_freeNext) != '0) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stallCnt = r_stall_cnt;
`endif

    property p_upstream_stable;
        @(posedge clk) disable iff (rst)
            (i_drive && !o_free) |=> ($stable(i_data) && $stable(i_mask));
    endproperty

    a_upstream_stable: assert property (p_upstream_stable);

endmodule

// File: tb/tb_mmu_fork_sync.sv
// Scoreboard bench for mmu_fork_sync: a full-through instance and a bubble instance.
module tb_mmu_fork_sync;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  mask;
    } tok_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_drive = 1'b0;
    logic        a_free;
    logic [31:0] a_data_in = '0;
    logic [2:0]  a_mask = '0;
    logic [2:0]  a_driveNext;
    logic [2:0]  a_freeNext = '0;
    logic [31:0] a_data;
    logic        a_busy;

    logic        b_drive = 1'b0;
    logic        b_free;
    logic [31:0] b_data_in = '0;
    logic [2:0]  b_mask = '0;
    logic [2:0]  b_driveNext;
    logic [2:0]  b_freeNext = '0;
    logic [31:0] b_data;
    logic        b_busy;

`ifdef MMU_FORK_STALL_CNT_EN
    logic [15:0] a_stall;
    logic [15:0] b_stall;
`endif

    int   checks = 0;
    int   errors = 0;
    tok_t sb_q[$];
    logic [2:0] acc = '0;

    logic [2:0] fn_tab  [6] = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000};
    logic [2:0] drv_tab [6] = '{3'b111, 3'b110, 3'b110, 3'b010, 3'b010, 3'b000};
    logic       fr_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    mmu_fork_sync #(.NUM_PORTS(3), .DATA_W(32), .FULL_THRU(1)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (a_drive),
        .o_free      (a_free),
        .i_data      (a_data_in),
        .i_mask      (a_mask),
        .o_driveNext (a_driveNext),
        .i_freeNext  (a_freeNext),
        .o_data      (a_data),
`ifdef MMU_FORK_STALL_CNT_EN
        .o_busy      (a_busy),
        .o_stallCnt  (a_stall)
`else
        .o_busy      (a_busy)
`endif
    );

    mmu_fork_sync #(.NUM_PORTS(3), .DATA_W(32), .FULL_THRU(0)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (b_drive),
        .o_free      (b_free),
        .i_data      (b_data_in),
        .i_mask      (b_mask),
        .o_driveNext (b_driveNext),
        .i_freeNext  (b_freeNext),
        .o_data      (b_data),
`ifdef MMU_FORK_STALL_CNT_EN
        .o_busy      (b_busy),
        .o_stallCnt  (b_stall)
`else
        .o_busy      (b_busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a token on instance A until accepted; expected branch traffic goes to the scoreboard.
    task automatic drive_token(input logic [31:0] d, input logic [2:0] m, output int waits);
        tok_t t;
        a_drive   = 1'b1;
        a_data_in = d;
        a_mask    = m;
        waits     = 0;
        while (1) begin
            @(negedge clk);
            if (a_free) break;
            waits++;
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: no accept after %0d cycles", waits);
                a_drive = 1'b0;
                return;
            end
            step();
        end
        if (m != 3'b000) begin
            t.data = d;
            t.mask = m;
            sb_q.push_back(t);
        end
        step();
    endtask

    // Monitor: every cycle a branch is driven, compare against the oldest outstanding token.
    always @(negedge clk) begin
        logic [2:0] fires;
        fires = a_driveNext & a_freeNext;
        if (rst) begin
            acc = '0;
        end else if (a_driveNext != 3'b000) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: driveNext 0x%0h with no token expected", a_driveNext);
            end else begin
                chk("sb_data", a_data, sb_q[0].data);
                chk("sb_drive", {29'd0, a_driveNext}, {29'd0, sb_q[0].mask & ~acc});
                acc = acc | fires;
                if (acc == sb_q[0].mask) begin
                    void'(sb_q.pop_front());
                    acc = '0;
                end
            end
        end
    end

    initial begin
        int w;
        int wsum;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_drive", {29'd0, a_driveNext}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_free", {31'd0, a_free}, 32'd1);
        chk("rst_data", a_data, 32'd0);
`ifdef MMU_FORK_STALL_CNT_EN
        chk("rst_stall", {16'd0, a_stall}, 32'd0);
`endif

        // Bubble instance: accepts in cycles 0 and 2, o_free low in cycle 1.
        step();
        b_freeNext = 3'b111;
        b_drive    = 1'b1;
        b_data_in  = 32'h1111_0001;
        b_mask     = 3'b111;
        @(negedge clk);
        chk("ft0_free_c0", {31'd0, b_free}, 32'd1);
        step();
        b_data_in  = 32'h2222_0002;
        @(negedge clk);
        chk("ft0_free_c1", {31'd0, b_free}, 32'd0);
        chk("ft0_drive_c1", {29'd0, b_driveNext}, 32'd7);
        chk("ft0_data_c1", b_data, 32'h1111_0001);
        step();
        @(negedge clk);
        chk("ft0_free_c2", {31'd0, b_free}, 32'd1);
        chk("ft0_drive_c2", {29'd0, b_driveNext}, 32'd0);
        step();
        b_drive = 1'b0;
        @(negedge clk);
        chk("ft0_drive_c3", {29'd0, b_driveNext}, 32'd7);
        chk("ft0_data_c3", b_data, 32'h2222_0002);
        step();

        // Broadcast, then sustained one-token-per-cycle.
        a_freeNext = 3'b111;
        drive_token(32'hA5A5_0001, 3'b111, w);
        a_drive = 1'b0;
        @(negedge clk);
        chk("bc_drive", {29'd0, a_driveNext}, 32'd7);
        chk("bc_data", a_data, 32'hA5A5_0001);
        step();
        wsum = 0;
        for (int k = 0; k < 4; k++) begin
            drive_token(32'hB000_0000 + 32'(k), 3'b111, w);
            wsum += w;
        end
        a_drive = 1'b0;
        chk("b2b_waits", 32'(wsum), 32'd0);
        step();
        step();

        // Eager skew with a fresh stall count.
        rst = 1'b1;
        sb_q.delete();
        step();
        rst = 1'b0;
        a_freeNext = 3'b000;
        drive_token(32'h1234_5678, 3'b111, w);
        a_drive = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_freeNext = fn_tab[i];
            @(negedge clk);
            chk($sformatf("skew_drive_c%0d", i + 1), {29'd0, a_driveNext}, {29'd0, drv_tab[i]});
            chk($sformatf("skew_free_c%0d", i + 1), {31'd0, a_free}, {31'd0, fr_tab[i]});
            chk($sformatf("skew_data_c%0d", i + 1), a_data, 32'h1234_5678);
`ifdef MMU_FORK_STALL_CNT_EN
            if (i == 5) chk("skew_stall", {16'd0, a_stall}, 32'd4);
`endif
            step();
        end

        // Masking: single branch, then an empty mask.
        a_freeNext = 3'b000;
        drive_token(32'hCAFE_0002, 3'b010, w);
        a_drive = 1'b0;
        @(negedge clk);
        chk("mask_drive", {29'd0, a_driveNext}, 32'd2);
        step();
        a_freeNext = 3'b010;
        step();
        a_freeNext = 3'b000;
        @(negedge clk);
        chk("mask_done", {29'd0, a_driveNext}, 32'd0);
        step();
        drive_token(32'hDEAD_0003, 3'b000, w);
        a_drive = 1'b0;
        chk("mask0_waits", 32'(w), 32'd0);
        @(negedge clk);
        chk("mask0_drive", {29'd0, a_driveNext}, 32'd0);
        chk("mask0_busy", {31'd0, a_busy}, 32'd0);
        chk("mask0_data", a_data, 32'hDEAD_0003);
        step();

        // Reset mid-token discards it; a late ready is ignored.
        drive_token(32'h0BAD_0005, 3'b101, w);
        a_drive = 1'b0;
        @(negedge clk);
        chk("mid_drive", {29'd0, a_driveNext}, 32'd5);
        chk("mid_busy", {31'd0, a_busy}, 32'd1);
        step();
        rst = 1'b1;
        sb_q.delete();
        step();
        rst = 1'b0;
        a_freeNext = 3'b101;
        @(negedge clk);
        chk("rmid_drive", {29'd0, a_driveNext}, 32'd0);
        chk("rmid_busy", {31'd0, a_busy}, 32'd0);
        chk("rmid_free", {31'd0, a_free}, 32'd1);
`ifdef MMU_FORK_STALL_CNT_EN
        chk("rmid_stall", {16'd0, a_stall}, 32'd0);
`endif
        step();
        @(negedge clk);
        chk("rmid_late", {29'd0, a_driveNext}, 32'd0);
        step();
        a_freeNext = 3'b000;

`ifdef MMU_FORK_STALL_CNT_EN
        drive_token(32'h0000_05A7, 3'b001, w);
        a_drive = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat_stall", {16'd0, a_stall}, 32'h0000_FFFF);
        chk("sat_drive", {29'd0, a_driveNext}, 32'd1);
        step();
        @(negedge clk);
        chk("sat_hold", {16'd0, a_stall}, 32'h0000_FFFF);
        step();
        a_freeNext = 3'b001;
        step();
        a_freeNext = 3'b000;
`endif

        step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
